// File: rtl/row_collapse.sv
// Purpose : clears every full (4'hF) row of an 8x4 board and drops the rows above it.
// Latency : done pulses 8+N cycles after the start edge (N = rows cleared); one row examined per cycle.
// Backpr. : no flow control; start is ignored while busy or done, so a request must be re-issued once idle.
// Build   : define ROW_COLLAPSE_SCORE_EN to add the saturating total_lines score counter.
module row_collapse (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] board_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] board_out,
  output logic [3:0]  lines_cleared
`ifdef ROW_COLLAPSE_SCORE_EN
  ,
  output logic [7:0]  total_lines
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] work;       // board being collapsed
  logic [2:0]  idx;        // row currently examined
  logic [3:0]  pass;       // rows cleared so far in this collapse

  logic [3:0]  cur_row;
  logic        row_full;
  logic [31:0] shift_all;
  logic [31:0] shifted;

`ifdef ROW_COLLAPSE_SCORE_EN
  logic [8:0]  total_sum;
  logic [7:0]  total_next;
`endif

  // Row under inspection and the board with that row removed (rows above drop by one).
  always_comb begin
    cur_row   = work[{idx, 2'b00} +: 4];
    row_full  = (cur_row == 4'hF);
    shift_all = {4'h0, work[31:4]};
    shifted   = work;
    for (int r = 0; r < 8; r++) begin
      if (3'(r) >= idx) begin
        shifted[4*r +: 4] = shift_all[4*r +: 4];
      end
    end
  end

`ifdef ROW_COLLAPSE_SCORE_EN
  // Score accumulates the count of the collapse being completed, clamped at 8'hFF.
  always_comb begin
    total_sum  = {1'b0, total_lines} + {5'b0, pass};
    total_next = total_sum[8] ? 8'hFF : total_sum[7:0];
  end
`endif

  // Collapse sequencer: latch on start, scan one row per cycle, publish results on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      work          <= 32'h0;
      idx           <= 3'd0;
      pass          <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      board_out     <= 32'h0;
      lines_cleared <= 4'h0;
`ifdef ROW_COLLAPSE_SCORE_EN
      total_lines   <= 8'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= board_in;
            idx   <= 3'd0;
            pass  <= 4'd0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (row_full) begin
            // Index stays put: the row that dropped into this slot still needs a look.
            work <= shifted;
            pass <= pass + 4'd1;
          end else if (idx == 3'd7) begin
            board_out     <= work;
            lines_cleared <= pass;
`ifdef ROW_COLLAPSE_SCORE_EN
            total_lines   <= total_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end

        DONE: begin
          // Any start seen here is dropped; the requester must retry from IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_collapse.sv
module tb_row_collapse;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] board_in;
  logic        busy;
  logic        done;
  logic [31:0] board_out;
  logic [3:0]  lines_cleared;
`ifdef ROW_COLLAPSE_SCORE_EN
  logic [7:0]  total_lines;
`endif

  int checks   = 0;
  int failures = 0;
  int tot_model = 0;

  row_collapse dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .board_in      (board_in),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .lines_cleared (lines_cleared)
`ifdef ROW_COLLAPSE_SCORE_EN
    ,
    .total_lines   (total_lines)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: keep non-full rows in bottom-to-top order, pad the top with empty rows.
  task automatic model(input logic [31:0] b, output logic [31:0] out, output int n);
    logic [3:0] keep[$];
    logic [3:0] row;
    keep.delete();
    for (int r = 0; r < 8; r++) begin
      row = b[4*r +: 4];
      if (row != 4'hF) keep.push_back(row);
    end
    n   = 8 - keep.size();
    out = 32'h0;
    for (int r = 0; r < keep.size(); r++) out[4*r +: 4] = keep[r];
  endtask

  // One complete collapse; optionally pokes start while busy and during the done cycle.
  task automatic run(input logic [31:0] b, input bit poke_busy, input bit poke_done);
    logic [31:0] exp_out;
    int          n;
    int          cycles;
    bit          got_done;
    model(b, exp_out, n);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    board_in = $urandom;
    check("busy_after_start", busy, 1);
    cycles   = 0;
    got_done = 0;
    while (!got_done && cycles < 40) begin
      start    = (poke_busy && cycles == 2);
      board_in = $urandom;
      @(posedge clk); #1;
      cycles++;
      if (done) got_done = 1;
    end
    start = 1'b0;
    check("latency", cycles, 8 + n);
    check("busy_at_done", busy, 0);
    check("board_out", board_out, exp_out);
    check("lines_cleared", lines_cleared, n);
    tot_model = (tot_model + n > 255) ? 255 : tot_model + n;
`ifdef ROW_COLLAPSE_SCORE_EN
    check("total_lines", total_lines, tot_model);
`endif
    if (poke_done) begin
      start    = 1'b1;
      board_in = 32'hFFFF_FFFF;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("board_out_held", board_out, exp_out);
  endtask

  initial begin
    logic [31:0] b;
    bit          saw_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    board_in = 32'h0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_board_out", board_out, 32'h0);
    check("rst_lines", lines_cleared, 0);
`ifdef ROW_COLLAPSE_SCORE_EN
    check("rst_total", total_lines, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed boards
    run(32'h0000_0F00, 0, 0);
    run(32'h1234_F5FF, 0, 1);
    run(32'hFFFF_FFFF, 1, 0);
    run(32'h8421_7EDB, 1, 1);

    // Reset in the middle of a scan abandons the collapse
    @(negedge clk);
    board_in = 32'hFFFF_FFFF;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_board_out", board_out, 32'h0);
    check("midrst_lines", lines_cleared, 0);
`ifdef ROW_COLLAPSE_SCORE_EN
    check("midrst_total", total_lines, 0);
`endif
    tot_model = 0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    saw_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    check("no_done_after_abort", saw_done, 0);
    check("board_out_after_abort", board_out, 32'h0);

    // Start accepted on the first edge after reset release
    rst_n = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(32'hFFFF_FFFF, 0, 0);

    // Randomized boards biased toward full rows
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < 8; r++) begin
        b[4*r +: 4] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      end
      run(b, k[0], k[1]);
    end

`ifdef ROW_COLLAPSE_SCORE_EN
    // Score saturation: clear, then 32 all-ones collapses (256 lines) must pin at 8'hFF
    rst_n = 1'b0;
    #3;
    tot_model = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) run(32'hFFFF_FFFF, 0, 0);
    check("total_saturated", total_lines, 8'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
